sram_lane_arbiter: RTL and testbench

- Parametrised memory front-end that builds one DATA_W-wide word memory from DATA_W/8 byte-wide single-port SRAM macros sharing one address bus.
- Arbitrates between two requesters, the CPU and the Wishbone-side loader/debug path, with per-byte write enables and a fixed-latency req/ack handshake.
- Sits between the SoC configuration block, the CPU and the SRAM macros.
- Generalises the fixed 16-bit, two-macro, CPU-only memory hookup.

---
 rtl/sram_lane_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_lane_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_lane_arbiter.sv
// sram_lane_arbiter: builds one DATA_W-wide word memory from DATA_W/8
// byte-wide single-port SRAM macros on a shared address bus. Two requesters
// (CPU and Wishbone-side loader/debug path) share it through a fixed-latency
// req/ack handshake with per-byte write enables.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/be   CPU command (req held until cpu_ack)
//   cpu_rdata, cpu_ack         CPU read data, one-cycle completion pulse
//   wb_req/we/addr/wdata/be    Wishbone-side command, same meaning
//   wb_rdata, wb_ack           Wishbone-side read data, completion pulse
//   mem_csb                    per-macro chip select, active low
//   mem_web                    shared write enable, active low
//   mem_addr, mem_din          shared macro address, lane-sliced write data
//   mem_dout                   macro read data, valid the cycle after access
//   busy                       high whenever the FSM is not in IDLE
module sram_lane_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int ARB_MODE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic [DATA_W/8-1:0]    cpu_be,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ack,
  input  logic                   wb_req,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_wdata,
  input  logic [DATA_W/8-1:0]    wb_be,
  output logic [DATA_W-1:0]      wb_rdata,
  output logic                   wb_ack,
  output logic [DATA_W/8-1:0]    mem_csb,
  output logic                   mem_web,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_din,
  input  logic [DATA_W-1:0]      mem_dout,
  output logic                   busy
);

  localparam int LANES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_nxt;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [LANES-1:0]    cmd_be;
  logic                grant_wb;   // 1 = current transaction belongs to WB
  logic                last_wb;    // round-robin pointer: 1 = WB granted last
  logic                pick_wb;
  logic                any_req;
  logic                rd_done;
  logic [DATA_W-1:0]   cpu_rdata_q, wb_rdata_q;

  assign any_req = cpu_req | wb_req;

  always_comb begin
    pick_wb = wb_req;
    if (ARB_MODE == 0) begin
      pick_wb = ~cpu_req;
    end else if (cpu_req && wb_req) begin
      pick_wb = ~last_wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_csb   = '1;
    mem_web   = 1'b1;
    case (state)
      IDLE:   if (any_req) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = DONE;
        if (cmd_we) begin
          mem_web = 1'b0;
          mem_csb = ~cmd_be;
        end else begin
          mem_csb = '0;
        end
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_be      <= '0;
      grant_wb    <= 1'b0;
      last_wb     <= 1'b1;
      cpu_rdata_q <= '0;
      wb_rdata_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_wb  <= pick_wb;
        cmd_we    <= pick_wb ? wb_we    : cpu_we;
        cmd_addr  <= pick_wb ? wb_addr  : cpu_addr;
        cmd_wdata <= pick_wb ? wb_wdata : cpu_wdata;
        cmd_be    <= pick_wb ? wb_be    : cpu_be;
      end
      if (state == DONE) begin
        last_wb <= grant_wb;
        if (!cmd_we) begin
          if (grant_wb) wb_rdata_q  <= mem_dout;
          else          cpu_rdata_q <= mem_dout;
        end
      end
    end
  end

  // The macro's read data only appears during DONE, yet rdata must be valid
  // alongside ack; the DONE cycle forwards mem_dout, the register holds it after.
  assign rd_done   = (state == DONE) && !cmd_we;
  assign cpu_rdata = (rd_done && !grant_wb) ? mem_dout : cpu_rdata_q;
  assign wb_rdata  = (rd_done &&  grant_wb) ? mem_dout : wb_rdata_q;

  assign cpu_ack  = (state == DONE) && !grant_wb;
  assign wb_ack   = (state == DONE) &&  grant_wb;
  assign mem_addr = cmd_addr;
  assign mem_din  = cmd_wdata;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sram_lane_arbiter.sv
module tb_sram_lane_arbiter;

  typedef struct {
    bit          wb;
    bit          we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [1:0]  exp_csb;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          wb;
    bit          rd;
    logic [31:0] rdata;
  } exp_t;

  logic clk, rst_n;
  int   n_cmp, n_err, cyc;
  exp_t sb[$];
  vec_t tbl[11];

  // Instance A: 16-bit, round-robin
  logic a_cpu_req, a_cpu_we, a_cpu_ack, a_wb_req, a_wb_we, a_wb_ack, a_mem_web, a_busy;
  logic [9:0]  a_cpu_addr, a_wb_addr, a_mem_addr;
  logic [15:0] a_cpu_wdata, a_cpu_rdata, a_wb_wdata, a_wb_rdata, a_mem_din, a_mem_dout;
  logic [1:0]  a_cpu_be, a_wb_be, a_mem_csb;
  // Instance B: 16-bit, fixed CPU priority
  logic b_cpu_req, b_cpu_we, b_cpu_ack, b_wb_req, b_wb_we, b_wb_ack, b_mem_web, b_busy;
  logic [9:0]  b_cpu_addr, b_wb_addr, b_mem_addr;
  logic [15:0] b_cpu_wdata, b_cpu_rdata, b_wb_wdata, b_wb_rdata, b_mem_din, b_mem_dout;
  logic [1:0]  b_cpu_be, b_wb_be, b_mem_csb;
  // Instance C: 32-bit data, 8-bit address
  logic c_cpu_req, c_cpu_we, c_cpu_ack, c_wb_req, c_wb_we, c_wb_ack, c_mem_web, c_busy;
  logic [7:0]  c_cpu_addr, c_wb_addr, c_mem_addr;
  logic [31:0] c_cpu_wdata, c_cpu_rdata, c_wb_wdata, c_wb_rdata, c_mem_din, c_mem_dout;
  logic [3:0]  c_cpu_be, c_wb_be, c_mem_csb;

  sram_lane_arbiter #(.DATA_W(16), .ADDR_W(10), .ARB_MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_be(a_cpu_be), .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack),
    .wb_req(a_wb_req), .wb_we(a_wb_we), .wb_addr(a_wb_addr), .wb_wdata(a_wb_wdata),
    .wb_be(a_wb_be), .wb_rdata(a_wb_rdata), .wb_ack(a_wb_ack),
    .mem_csb(a_mem_csb), .mem_web(a_mem_web), .mem_addr(a_mem_addr), .mem_din(a_mem_din),
    .mem_dout(a_mem_dout), .busy(a_busy));

  sram_lane_arbiter #(.DATA_W(16), .ADDR_W(10), .ARB_MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_be(b_cpu_be), .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .wb_req(b_wb_req), .wb_we(b_wb_we), .wb_addr(b_wb_addr), .wb_wdata(b_wb_wdata),
    .wb_be(b_wb_be), .wb_rdata(b_wb_rdata), .wb_ack(b_wb_ack),
    .mem_csb(b_mem_csb), .mem_web(b_mem_web), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
    .mem_dout(b_mem_dout), .busy(b_busy));

  sram_lane_arbiter #(.DATA_W(32), .ADDR_W(8), .ARB_MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(c_cpu_req), .cpu_we(c_cpu_we), .cpu_addr(c_cpu_addr), .cpu_wdata(c_cpu_wdata),
    .cpu_be(c_cpu_be), .cpu_rdata(c_cpu_rdata), .cpu_ack(c_cpu_ack),
    .wb_req(c_wb_req), .wb_we(c_wb_we), .wb_addr(c_wb_addr), .wb_wdata(c_wb_wdata),
    .wb_be(c_wb_be), .wb_rdata(c_wb_rdata), .wb_ack(c_wb_ack),
    .mem_csb(c_mem_csb), .mem_web(c_mem_web), .mem_addr(c_mem_addr), .mem_din(c_mem_din),
    .mem_dout(c_mem_dout), .busy(c_busy));

  // Byte-wide synchronous single-port macro models
  logic [15:0] a_ram [0:1023];
  logic [15:0] b_ram [0:1023];
  logic [31:0] c_ram [0:255];

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (!a_mem_csb[i]) begin
        if (!a_mem_web) a_ram[a_mem_addr][8*i +: 8] <= a_mem_din[8*i +: 8];
        else            a_mem_dout[8*i +: 8] <= a_ram[a_mem_addr][8*i +: 8];
      end

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (!b_mem_csb[i]) begin
        if (!b_mem_web) b_ram[b_mem_addr][8*i +: 8] <= b_mem_din[8*i +: 8];
        else            b_mem_dout[8*i +: 8] <= b_ram[b_mem_addr][8*i +: 8];
      end

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (!c_mem_csb[i]) begin
        if (!c_mem_web) c_ram[c_mem_addr][8*i +: 8] <= c_mem_din[8*i +: 8];
        else            c_mem_dout[8*i +: 8] <= c_ram[c_mem_addr][8*i +: 8];
      end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  task automatic pop_a();
    exp_t e;
    if (sb.size() == 0) begin
      fail("a_unexpected_ack");
      return;
    end
    e = sb.pop_front();
    chk("a_ack_who", 32'({a_cpu_ack, a_wb_ack}), 32'(e.wb ? 2'b01 : 2'b10));
    if (e.rd) chk("a_rdata", 32'(e.wb ? a_wb_rdata : a_cpu_rdata), e.rdata);
  endtask

  task automatic txn_a(input vec_t v);
    int lat;
    sb.push_back('{wb: v.wb, rd: !v.we, rdata: 32'(v.exp_rdata)});
    @(negedge clk);
    if (v.wb) begin
      a_wb_req = 1'b1; a_wb_we = v.we; a_wb_addr = v.addr; a_wb_wdata = v.wdata; a_wb_be = v.be;
    end else begin
      a_cpu_req = 1'b1; a_cpu_we = v.we; a_cpu_addr = v.addr; a_cpu_wdata = v.wdata; a_cpu_be = v.be;
    end
    @(negedge clk);
    chk("a_csb", 32'(a_mem_csb), 32'(v.exp_csb));
    chk("a_web", 32'(a_mem_web), 32'(!v.we));
    chk("a_addr", 32'(a_mem_addr), 32'(v.addr));
    if (v.we) chk("a_din", 32'(a_mem_din), 32'(v.wdata));
    chk("a_busy_access", 32'(a_busy), 32'(1));
    lat = 1;
    while (!(a_cpu_ack || a_wb_ack) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("a_latency", 32'(lat), 32'(2));
    if (a_cpu_ack || a_wb_ack) pop_a();
    a_cpu_req = 1'b0;
    a_wb_req  = 1'b0;
    @(negedge clk);
    chk("a_busy_idle", 32'(a_busy), 32'(0));
  endtask

  task automatic txn_c(input bit we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [3:0] exp_csb, input logic [31:0] exp_rd);
    int   lat;
    exp_t e;
    sb.push_back('{wb: 1'b0, rd: !we, rdata: exp_rd});
    @(negedge clk);
    c_cpu_req = 1'b1; c_cpu_we = we; c_cpu_addr = addr; c_cpu_wdata = wdata; c_cpu_be = be;
    @(negedge clk);
    chk("c_csb", 32'(c_mem_csb), 32'(exp_csb));
    lat = 1;
    while (!c_cpu_ack && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("c_latency", 32'(lat), 32'(2));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (c_cpu_ack && e.rd) chk("c_rdata", c_cpu_rdata, e.rdata);
    end
    c_cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   acks, last_cyc;
    exp_t e;
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0;
    {a_cpu_req, a_cpu_we, a_cpu_addr, a_cpu_wdata, a_cpu_be} = '0;
    {a_wb_req, a_wb_we, a_wb_addr, a_wb_wdata, a_wb_be} = '0;
    {b_cpu_req, b_cpu_we, b_cpu_addr, b_cpu_wdata, b_cpu_be} = '0;
    {b_wb_req, b_wb_we, b_wb_addr, b_wb_wdata, b_wb_be} = '0;
    {c_cpu_req, c_cpu_we, c_cpu_addr, c_cpu_wdata, c_cpu_be} = '0;
    {c_wb_req, c_wb_we, c_wb_addr, c_wb_wdata, c_wb_be} = '0;

    tbl[0]  = '{wb:0, we:1, addr:10'h155, wdata:16'hBEEF, be:2'b11, exp_csb:2'b00, exp_rdata:16'h0};
    tbl[1]  = '{wb:0, we:0, addr:10'h155, wdata:16'h0,    be:2'b11, exp_csb:2'b00, exp_rdata:16'hBEEF};
    tbl[2]  = '{wb:0, we:1, addr:10'h003, wdata:16'h1234, be:2'b11, exp_csb:2'b00, exp_rdata:16'h0};
    tbl[3]  = '{wb:0, we:1, addr:10'h003, wdata:16'hAB00, be:2'b10, exp_csb:2'b01, exp_rdata:16'h0};
    tbl[4]  = '{wb:0, we:0, addr:10'h003, wdata:16'h0,    be:2'b11, exp_csb:2'b00, exp_rdata:16'hAB34};
    tbl[5]  = '{wb:0, we:1, addr:10'h007, wdata:16'h5A5A, be:2'b11, exp_csb:2'b00, exp_rdata:16'h0};
    tbl[6]  = '{wb:0, we:1, addr:10'h007, wdata:16'hFFFF, be:2'b00, exp_csb:2'b11, exp_rdata:16'h0};
    tbl[7]  = '{wb:0, we:0, addr:10'h007, wdata:16'h0,    be:2'b11, exp_csb:2'b00, exp_rdata:16'h5A5A};
    tbl[8]  = '{wb:1, we:1, addr:10'h3FF, wdata:16'h0F0F, be:2'b11, exp_csb:2'b00, exp_rdata:16'h0};
    tbl[9]  = '{wb:1, we:1, addr:10'h3FF, wdata:16'hC3C3, be:2'b01, exp_csb:2'b10, exp_rdata:16'h0};
    tbl[10] = '{wb:1, we:0, addr:10'h3FF, wdata:16'h0,    be:2'b11, exp_csb:2'b00, exp_rdata:16'h0FC3};

    // Reset values
    #12;
    chk("rst_csb", 32'(a_mem_csb), 32'(2'b11));
    chk("rst_web", 32'(a_mem_web), 32'(1));
    chk("rst_addr", 32'(a_mem_addr), 32'(0));
    chk("rst_din", 32'(a_mem_din), 32'(0));
    chk("rst_acks", 32'({a_cpu_ack, a_wb_ack}), 32'(0));
    chk("rst_rdata", 32'({a_cpu_rdata, a_wb_rdata}), 32'(0));
    chk("rst_busy", 32'(a_busy), 32'(0));
    chk("rst_c_csb", 32'(c_mem_csb), 32'(4'hF));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) txn_a(tbl[i]);
    chk("a_cpu_rdata_hold", 32'(a_cpu_rdata), 32'(16'h5A5A));
    chk("a_wb_rdata_hold", 32'(a_wb_rdata), 32'(16'h0FC3));

    // Round-robin: both request together and hold; pointer says WB went last.
    for (int k = 0; k < 4; k++)
      sb.push_back('{wb: (k % 2 == 1), rd: 1'b1, rdata: (k % 2 == 1) ? 32'h0000AB34 : 32'h0000BEEF});
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 10'h155; a_cpu_be = 2'b11;
    a_wb_req  = 1'b1; a_wb_we  = 1'b0; a_wb_addr  = 10'h003; a_wb_be  = 2'b11;
    acks = 0; last_cyc = 0;
    for (int t = 0; t < 40 && acks < 4; t++) begin
      @(negedge clk);
      if (a_cpu_ack || a_wb_ack) begin
        pop_a();
        if (acks > 0) chk("a_rr_gap", 32'(cyc - last_cyc), 32'(3));
        last_cyc = cyc;
        acks++;
      end
    end
    if (acks < 4) fail("a_rr_ack_timeout");
    a_cpu_req = 1'b0; a_wb_req = 1'b0;
    @(negedge clk);

    // Fixed priority: WB starves until the CPU lets go.
    for (int k = 0; k < 5; k++) sb.push_back('{wb: (k == 4), rd: 1'b0, rdata: 32'h0});
    @(negedge clk);
    b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 10'h001; b_cpu_wdata = 16'h1111; b_cpu_be = 2'b11;
    b_wb_req  = 1'b1; b_wb_we  = 1'b1; b_wb_addr  = 10'h002; b_wb_wdata  = 16'h2222; b_wb_be  = 2'b11;
    acks = 0; last_cyc = 0;
    for (int t = 0; t < 50 && acks < 5; t++) begin
      @(negedge clk);
      if (b_cpu_ack || b_wb_ack) begin
        if (sb.size() == 0) fail("b_unexpected_ack");
        else begin
          e = sb.pop_front();
          chk("b_ack_who", 32'({b_cpu_ack, b_wb_ack}), 32'(e.wb ? 2'b01 : 2'b10));
        end
        if (acks > 0) chk("b_gap", 32'(cyc - last_cyc), 32'(3));
        last_cyc = cyc;
        acks++;
        if (acks == 4) b_cpu_req = 1'b0;
      end
    end
    if (acks < 5) fail("b_ack_timeout");
    b_cpu_req = 1'b0; b_wb_req = 1'b0;
    @(negedge clk);

    // Reset asserted during the ACCESS cycle of a read
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 10'h003; a_cpu_be = 2'b11;
    @(negedge clk);
    chk("mid_busy_before", 32'(a_busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_csb", 32'(a_mem_csb), 32'(2'b11));
    chk("mid_acks", 32'({a_cpu_ack, a_wb_ack}), 32'(0));
    chk("mid_busy", 32'(a_busy), 32'(0));
    chk("mid_rdata", 32'(a_cpu_rdata), 32'(0));
    a_cpu_req = 1'b0;
    @(negedge clk);
    chk("mid_acks_after", 32'({a_cpu_ack, a_wb_ack}), 32'(0));
    rst_n = 1'b1;
    txn_a('{wb:0, we:0, addr:10'h155, wdata:16'h0, be:2'b11, exp_csb:2'b00, exp_rdata:16'hBEEF});

    // 32-bit build: sparse byte enables over a zeroed word
    txn_c(1'b1, 8'h10, 32'h00000000, 4'hF, 4'h0, 32'h0);
    txn_c(1'b1, 8'h10, 32'hDEADBEEF, 4'b0101, 4'b1010, 32'h0);
    txn_c(1'b0, 8'h10, 32'h0, 4'hF, 4'h0, 32'h00AD00EF);

    if (sb.size() != 0) fail("scoreboard_leftover");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
